// File: rtl/sys_ctrl_burst_fsm_pkg.sv
// Shared definitions for the host debug/control burst engine.
// Contents: opcodes, ACK/NAK values, state encodings (also visible on the
// state_out debug port), STATUS reply bit positions, and a sizing helper.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_HALT     = 8'h00;
  localparam logic [7:0] OP_RESUME   = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_RESET    = 8'h04;
  localparam logic [7:0] OP_PING     = 8'h05;
  localparam logic [7:0] OP_HOLD_RST = 8'h06;
  localparam logic [7:0] OP_REL_RST  = 8'h07;
  localparam logic [7:0] OP_STATUS   = 8'h08;

  localparam logic [7:0] RSP_ACK = 8'h00;
  localparam logic [7:0] RSP_NAK = 8'hFF;

  // STATUS reply bit positions; the low nibble is always zero.
  localparam int unsigned STAT_HALT   = 7;
  localparam int unsigned STAT_HALTED = 6;
  localparam int unsigned STAT_RST    = 5;
  localparam int unsigned STAT_SAFE   = 4;

  typedef enum logic [7:0] {
    S_IDLE      = 8'h00,
    S_ARG_ADDR  = 8'h01,
    S_ARG_LEN   = 8'h02,
    S_WR_DATA   = 8'h03,
    S_WR_STROBE = 8'h04,
    S_RD_STROBE = 8'h05,
    S_RD_WAIT   = 8'h06,
    S_RD_SEND   = 8'h07,
    S_HALT_WAIT = 8'h08,
    S_RESET_CNT = 8'h09,
    S_SEND      = 8'h0A
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sys_ctrl_burst_fsm_if.sv
// UART byte stream, CPU memory bus and CPU control bundle of the debug engine.
// master: the engine (consumes rx bytes, drives tx, bus, halt/reset, debug state)
// slave : the surrounding system (UART, memory, CPU)
interface sys_ctrl_burst_fsm_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] cpu_bus_addr;
  logic [7:0]        cpu_bus_data_in;
  logic [7:0]        cpu_bus_data_out;
  logic              cpu_bus_write_en;
  logic              cpu_bus_read_en;
  logic              cpu_halt;
  logic              cpu_rst;
  logic              cpu_is_halted;
  logic              cpu_sys_mux_ctrl;
  logic [7:0]        state_out;

  modport master (
    input  rx_valid, rx_data, tx_ready, cpu_bus_data_in, cpu_is_halted,
    output tx_start, tx_data, cpu_bus_addr, cpu_bus_data_out, cpu_bus_write_en,
           cpu_bus_read_en, cpu_halt, cpu_rst, cpu_sys_mux_ctrl, state_out
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, cpu_bus_data_in, cpu_is_halted,
    input  tx_start, tx_data, cpu_bus_addr, cpu_bus_data_out, cpu_bus_write_en,
           cpu_bus_read_en, cpu_halt, cpu_rst, cpu_sys_mux_ctrl, state_out
  );
endinterface

// File: rtl/sys_ctrl_burst_fsm_timeout.sv
// Loadable down-counter with clear and enable.
// Ports: clk, rst (async, active-low), load/load_val (highest priority),
// clr (zero the count), en (count down while non-zero),
// expired (combinational, high for the one enabled cycle in which count==1,
// i.e. after exactly load_val enabled cycles).
module sys_ctrl_timeout #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expired = en && !load && (cnt == W'(1));
endmodule

// File: rtl/sys_ctrl_burst_fsm.sv
// Host-side debug/control engine: decodes single-byte commands from a UART
// byte stream, performs halt/resume/reset control and burst peek/poke on the
// CPU bus (only while bus_safe), and answers with ACK/NAK/data bytes.
// Ports: clk, rst (async, active-low), bus (master modport: rx/tx bytes,
// CPU bus, cpu_halt/cpu_rst/cpu_is_halted, cpu_sys_mux_ctrl, state_out).
module sys_ctrl_burst_fsm
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned RST_CYC    = 256,
  parameter int unsigned HALT_WAIT  = 1024,
  parameter int unsigned RX_TIMEOUT = 2_000_000
) (
  input logic                  clk,
  input logic                  rst,
  sys_ctrl_burst_fsm_if.master bus
);
  localparam int unsigned ADDR_W = 8 * ADDR_BYTES;
  localparam int unsigned TW     = $clog2(max3(RX_TIMEOUT, HALT_WAIT, RST_CYC) + 1);
  localparam int unsigned LW     = $clog2(READ_LAT + 1);

  state_t            state, next_state, ret_state, next_ret;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        burst_cnt, byte_cnt, tx_data_q, data_out_q;
  logic [LW-1:0]     lat_cnt;
  logic              is_read, wr_err, cpu_halt_q, cpu_rst_q, bus_safe;
  logic              send_load;
  logic [7:0]        send_val, status;
  logic              rx_load, rx_en, rx_exp, hw_load, hw_en, hw_exp, rc_load, rc_en, rc_exp;
  logic              idle;

  assign bus_safe = (cpu_halt_q & bus.cpu_is_halted) | ~cpu_rst_q;
  assign idle     = (state == S_IDLE);

  always_comb begin
    status              = '0;
    status[STAT_HALT]   = cpu_halt_q;
    status[STAT_HALTED] = bus.cpu_is_halted;
    status[STAT_RST]    = cpu_rst_q;
    status[STAT_SAFE]   = bus_safe;
  end

  sys_ctrl_timeout #(.W(TW)) u_rx_to (
    .clk(clk), .rst(rst), .load(rx_load), .load_val(TW'(RX_TIMEOUT)),
    .clr(idle), .en(rx_en), .expired(rx_exp));
  sys_ctrl_timeout #(.W(TW)) u_halt_to (
    .clk(clk), .rst(rst), .load(hw_load), .load_val(TW'(HALT_WAIT)),
    .clr(idle), .en(hw_en), .expired(hw_exp));
  sys_ctrl_timeout #(.W(TW)) u_rst_to (
    .clk(clk), .rst(rst), .load(rc_load), .load_val(TW'(RST_CYC)),
    .clr(idle), .en(rc_en), .expired(rc_exp));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; also picks the response byte and where SEND returns to.
  always_comb begin
    next_state = state;
    next_ret   = ret_state;
    send_load  = 1'b0;
    send_val   = RSP_ACK;
    case (state)
      S_IDLE: if (bus.rx_valid) begin
        next_ret  = S_IDLE;
        send_load = 1'b1;
        next_state = S_SEND;
        case (bus.rx_data)
          OP_HALT:           begin next_state = S_HALT_WAIT; send_load = 1'b0; end
          OP_WRITE, OP_READ: begin next_state = S_ARG_ADDR;  send_load = 1'b0; end
          OP_RESET:          begin next_state = S_RESET_CNT; send_load = 1'b0; end
          OP_RESUME, OP_PING, OP_HOLD_RST, OP_REL_RST: send_val = RSP_ACK;
          OP_STATUS:         send_val = status;
          default:           send_val = RSP_NAK;
        endcase
      end
      S_ARG_ADDR: begin
        if (bus.rx_valid) begin
          if (byte_cnt == 8'(ADDR_BYTES - 1)) next_state = S_ARG_LEN;
        end else if (rx_exp) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_NAK;
        end
      end
      S_ARG_LEN: begin
        if (bus.rx_valid) begin
          if (!is_read)      next_state = S_WR_DATA;
          else if (bus_safe) next_state = S_RD_STROBE;
          else begin
            next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_NAK;
          end
        end else if (rx_exp) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_NAK;
        end
      end
      S_WR_DATA: begin
        if (bus.rx_valid) next_state = S_WR_STROBE;
        else if (rx_exp) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_NAK;
        end
      end
      S_WR_STROBE: begin
        if (burst_cnt == 8'd0) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1;
          send_val   = (wr_err || !bus_safe) ? RSP_NAK : RSP_ACK;
        end else begin
          next_state = S_WR_DATA;
        end
      end
      S_RD_STROBE: next_state = S_RD_WAIT;
      S_RD_WAIT: if (lat_cnt == '0) begin
        next_state = S_SEND; next_ret = S_RD_SEND; send_load = 1'b1;
        send_val   = bus.cpu_bus_data_in;
      end
      S_RD_SEND: next_state = (burst_cnt == 8'd0) ? S_IDLE : S_RD_STROBE;
      S_HALT_WAIT: begin
        if (bus.cpu_is_halted) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_ACK;
        end else if (hw_exp) begin
          next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_NAK;
        end
      end
      S_RESET_CNT: if (rc_exp) begin
        next_state = S_SEND; next_ret = S_IDLE; send_load = 1'b1; send_val = RSP_ACK;
      end
      S_SEND: if (bus.tx_ready) next_state = ret_state;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode: strobes and timer controls
  always_comb begin
    bus.tx_start         = (state == S_SEND) && bus.tx_ready;
    bus.cpu_bus_write_en = (state == S_WR_STROBE) && bus_safe;
    bus.cpu_bus_read_en  = (state == S_RD_STROBE) && bus_safe;
    rx_en   = (state == S_ARG_ADDR) || (state == S_ARG_LEN) || (state == S_WR_DATA);
    rx_load = bus.rx_valid &&
              (rx_en || (idle && (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ)));
    hw_en   = (state == S_HALT_WAIT);
    hw_load = idle && bus.rx_valid && (bus.rx_data == OP_HALT);
    rc_en   = (state == S_RESET_CNT);
    rc_load = idle && bus.rx_valid && (bus.rx_data == OP_RESET);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_state  <= S_IDLE;
      addr       <= '0;
      burst_cnt  <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      tx_data_q  <= '0;
      data_out_q <= '0;
      is_read    <= 1'b0;
      wr_err     <= 1'b0;
      cpu_halt_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      ret_state <= next_ret;
      if (send_load) tx_data_q <= send_val;
      case (state)
        S_IDLE: if (bus.rx_valid) begin
          case (bus.rx_data)
            OP_HALT:              cpu_halt_q <= 1'b1;
            OP_RESUME:            cpu_halt_q <= 1'b0;
            OP_WRITE:             begin is_read <= 1'b0; byte_cnt <= '0; wr_err <= 1'b0; end
            OP_READ:              begin is_read <= 1'b1; byte_cnt <= '0; end
            OP_RESET, OP_HOLD_RST: cpu_rst_q <= 1'b0;
            OP_REL_RST:           cpu_rst_q <= 1'b1;
            default: ;
          endcase
        end
        // Address bytes arrive MSB-first: shift the accumulated value up.
        S_ARG_ADDR: if (bus.rx_valid) begin
          addr     <= ADDR_W'({addr, bus.rx_data});
          byte_cnt <= byte_cnt + 8'd1;
        end
        S_ARG_LEN:  if (bus.rx_valid) burst_cnt  <= bus.rx_data;
        S_WR_DATA:  if (bus.rx_valid) data_out_q <= bus.rx_data;
        S_WR_STROBE: begin
          addr <= addr + ADDR_W'(1);
          if (!bus_safe)          wr_err    <= 1'b1;
          if (burst_cnt != 8'd0)  burst_cnt <= burst_cnt - 8'd1;
        end
        S_RD_STROBE: lat_cnt <= LW'(READ_LAT - 1);
        S_RD_WAIT:   if (lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
        S_RD_SEND: begin
          addr <= addr + ADDR_W'(1);
          if (burst_cnt != 8'd0) burst_cnt <= burst_cnt - 8'd1;
        end
        S_RESET_CNT: if (rc_exp) cpu_rst_q <= 1'b1;
        S_HALT_WAIT, S_SEND: ;
        // An illegal state code returns the CPU controls to their reset values.
        default: begin
          cpu_halt_q <= 1'b0;
          cpu_rst_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_data          = tx_data_q;
  assign bus.cpu_bus_addr     = addr;
  assign bus.cpu_bus_data_out = data_out_q;
  assign bus.cpu_halt         = cpu_halt_q;
  assign bus.cpu_rst          = cpu_rst_q;
  assign bus.cpu_sys_mux_ctrl = bus_safe;
  assign bus.state_out        = state;
endmodule

// File: tb/tb_sys_ctrl_burst_fsm.sv
// Directed testbench for sys_ctrl_burst_fsm with a queue-based scoreboard.
module tb_sys_ctrl_burst_fsm;
  import sys_ctrl_pkg::*;

  localparam int unsigned RXT = 300;
  localparam int unsigned HW  = 1024;
  localparam int unsigned RC  = 256;
  localparam int unsigned RL  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_burst_fsm_if #(.ADDR_W(16)) bif ();

  sys_ctrl_burst_fsm #(
    .ADDR_BYTES(2), .READ_LAT(RL), .RST_CYC(RC), .HALT_WAIT(HW), .RX_TIMEOUT(RXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_tx [$];
  logic [23:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  int unsigned checks = 0, errors = 0;
  int unsigned rd_seen = 0, hw_cyc = 0, rstlow_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // UART TX model: busy for a few cycles after each start strobe
  initial begin
    bif.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && bif.tx_start) begin
        @(posedge clk); #1 bif.tx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bif.tx_ready = 1'b1;
      end
    end
  end

  // Memory model: data valid only in the cycle READ_LAT after the strobe
  initial begin
    logic [15:0] a;
    bif.cpu_bus_data_in = 8'hEE;
    forever begin
      @(negedge clk);
      if (rst && bif.cpu_bus_read_en) begin
        a = bif.cpu_bus_addr;
        repeat (RL) @(posedge clk);
        #1 bif.cpu_bus_data_in = mem[a];
        @(posedge clk);
        #1 bif.cpu_bus_data_in = 8'hEE;
      end
    end
  end

  // Cycle counters for HALT_WAIT residency and cpu_rst low time
  initial forever begin
    @(negedge clk);
    if (rst && bif.state_out == S_HALT_WAIT) hw_cyc++;
    if (rst && !bif.cpu_rst) rstlow_cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output event
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (bif.tx_start) begin
        if (exp_tx.size() == 0) check("tx_extra", 32'(exp_tx.size()), 32'd1);
        else check("tx_byte", 32'(bif.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bif.cpu_bus_write_en) begin
        if (exp_wr.size() == 0) check("wr_extra", 32'(exp_wr.size()), 32'd1);
        else check("wr_addr_data", 32'({bif.cpu_bus_addr, bif.cpu_bus_data_out}),
                   32'(exp_wr.pop_front()));
      end
      if (bif.cpu_bus_read_en) begin
        rd_seen++;
        if (exp_rd.size() == 0) check("rd_extra", 32'(exp_rd.size()), 32'd1);
        else check("rd_addr", 32'(bif.cpu_bus_addr), 32'(exp_rd.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 bif.rx_valid = 1'b1; bif.rx_data = b;
    @(posedge clk); #1 bif.rx_valid = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((exp_tx.size() != 0 || bif.state_out != S_IDLE) && n < budget) begin
      @(posedge clk); n++;
    end
    #1 check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_tx_start", 32'(bif.tx_start), 32'd0);
    check("rst_tx_data", 32'(bif.tx_data), 32'd0);
    check("rst_addr", 32'(bif.cpu_bus_addr), 32'd0);
    check("rst_data_out", 32'(bif.cpu_bus_data_out), 32'd0);
    check("rst_write_en", 32'(bif.cpu_bus_write_en), 32'd0);
    check("rst_read_en", 32'(bif.cpu_bus_read_en), 32'd0);
    check("rst_cpu_halt", 32'(bif.cpu_halt), 32'd0);
    check("rst_cpu_rst", 32'(bif.cpu_rst), 32'd1);
    check("rst_state", 32'(bif.state_out), 32'd0);
    check("rst_mux", 32'(bif.cpu_sys_mux_ctrl), 32'd0);
  endtask

  initial begin
    int unsigned snap;
    bif.rx_valid = 1'b0;
    bif.rx_data = 8'h00;
    bif.cpu_is_halted = 1'b0;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;

    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // PING and STATUS out of reset
    exp_tx.push_back(RSP_ACK); send_byte(OP_PING); wait_done("ping", 50);
    exp_tx.push_back(8'h20);   send_byte(OP_STATUS); wait_done("status", 50);

    // HALT acknowledged 10 cycles later
    exp_tx.push_back(RSP_ACK);
    send_byte(OP_HALT);
    repeat (2) @(posedge clk);
    #1 bif.cpu_is_halted = 1'b1;
    wait_done("halt_ack", 100);
    check("mux_after_halt", 32'(bif.cpu_sys_mux_ctrl), 32'd1);

    // Burst write of 3 bytes from 0x1234
    exp_wr.push_back({16'h1234, 8'hAA});
    exp_wr.push_back({16'h1235, 8'hBB});
    exp_wr.push_back({16'h1236, 8'hCC});
    exp_tx.push_back(RSP_ACK);
    send_byte(OP_WRITE); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_done("write_burst", 100);

    // Burst read wrapping FFFE -> 0000
    exp_rd.push_back(16'hFFFE); exp_rd.push_back(16'hFFFF); exp_rd.push_back(16'h0000);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    send_byte(OP_READ); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h02);
    wait_done("read_burst", 200);
    check("read_addr_wrapped", 32'(bif.cpu_bus_addr), 32'h0001);

    // Resume, then HALT that is never acknowledged
    bif.cpu_is_halted = 1'b0;
    exp_tx.push_back(RSP_ACK); send_byte(OP_RESUME); wait_done("resume", 50);
    check("halt_after_resume", 32'(bif.cpu_halt), 32'd0);
    snap = hw_cyc;
    exp_tx.push_back(RSP_NAK); send_byte(OP_HALT); wait_done("halt_timeout", HW + 100);
    check("halt_wait_cycles", hw_cyc - snap, HW);
    check("halt_held_after_nak", 32'(bif.cpu_halt), 32'd1);

    // READ while unsafe: single NAK, no strobe
    snap = rd_seen;
    exp_tx.push_back(RSP_NAK);
    send_byte(OP_READ); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_done("read_unsafe", 50);
    check("read_unsafe_strobes", rd_seen - snap, 32'd0);

    // Inter-byte timeout during argument collection, then PING
    exp_tx.push_back(RSP_NAK);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h10);
    wait_done("rx_timeout", RXT + 100);
    exp_tx.push_back(RSP_ACK); send_byte(OP_PING); wait_done("ping_after_to", 50);

    // RESET command holds cpu_rst low for RST_CYC cycles
    snap = rstlow_cyc;
    exp_tx.push_back(RSP_ACK); send_byte(OP_RESET); wait_done("reset_cmd", RC + 100);
    check("reset_low_cycles", rstlow_cyc - snap, RC);

    // Unknown opcode leaves CPU controls alone
    exp_tx.push_back(RSP_NAK); send_byte(8'h5A); wait_done("bad_opcode", 50);
    check("bad_op_cpu_rst", 32'(bif.cpu_rst), 32'd1);
    check("bad_op_cpu_halt", 32'(bif.cpu_halt), 32'd1);

    // Asynchronous reset in the middle of a burst write
    bif.cpu_is_halted = 1'b1;
    exp_wr.push_back({16'h0020, 8'hAA});
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h20); send_byte(8'h03);
    send_byte(8'hAA);
    @(posedge clk); #3 rst = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bif.cpu_is_halted = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("post_abort_state", 32'(bif.state_out), 32'd0);
    check("tx_queue_left", 32'(exp_tx.size()), 32'd0);
    check("wr_queue_left", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_left", 32'(exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
